// File: rtl/result_formatter_if.sv
// rtl/result_formatter_if.sv - request/result bundle between a result producer and the formatter
interface result_formatter_if #(
  parameter int MANT_W = 34,
  parameter int DIGITS = 11
);
  logic                  start;
  logic                  signIn;
  logic [MANT_W-1:0]     mantIn;
  logic [6:0]            expIn;
  logic                  busy;
  logic                  done;
  logic                  signOut;
  logic [4*DIGITS-1:0]   digits;
  logic [3:0]            numDigits;
  logic [6:0]            expOut;
  logic                  expSat;

  modport master (
    output start, signIn, mantIn, expIn,
    input  busy, done, signOut, digits, numDigits, expOut, expSat
  );

  modport slave (
    input  start, signIn, mantIn, expIn,
    output busy, done, signOut, digits, numDigits, expOut, expSat
  );
endinterface

// File: rtl/result_formatter.sv
// rtl/result_formatter.sv - binary mantissa to packed BCD with trailing-zero stripping into the exponent
module result_formatter #(
  parameter int MANT_W = 34,
  parameter int DIGITS = 11
) (
  input logic               clock,
  input logic               reset,
  result_formatter_if.slave fmt
);
  localparam int              BCD_W      = 4 * DIGITS;
  localparam logic [5:0]      LAST_ITER  = 6'(MANT_W - 1);
  localparam logic [3:0]      MAX_STRIPS = 4'(DIGITS - 1);
  localparam logic signed [6:0] EXP_MAX  = 7'sd63;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CONVERT = 3'd1;
  localparam logic [2:0] S_STRIP   = 3'd2;
  localparam logic [2:0] S_COUNT   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]          state;
  logic                startPrev;
  logic                startRise;
  logic                signReg;
  logic signed [6:0]   expReg;
  logic [MANT_W-1:0]   mantReg;
  logic [BCD_W-1:0]    bcdReg;
  logic [BCD_W-1:0]    bcdAdj;
  logic [5:0]          iterCnt;
  logic [3:0]          stripCnt;
  logic                satFlag;
  logic                digit0Zero;
  logic                upperNonZero;
  logic                expAtMax;
  logic                canStrip;
  logic                bcdZero;
  logic [3:0]          sigCount;

  // A conversion is requested only by a fresh 0->1 transition on start
  assign startRise = fmt.start & ~startPrev;

  // Strip decision: a trailing zero with something above it, while the exponent still has headroom
  assign digit0Zero   = (bcdReg[3:0] == 4'd0);
  assign upperNonZero = |bcdReg[BCD_W-1:4];
  assign expAtMax     = (expReg >= EXP_MAX);
  assign canStrip     = digit0Zero && upperNonZero && !expAtMax && (stripCnt < MAX_STRIPS);
  assign bcdZero      = (bcdReg == '0);

  // Double-dabble correction: every nibble of 5 or more gets +3 before the shift
  always_comb begin
    bcdAdj = bcdReg;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcdReg[4*i +: 4] >= 4'd5) begin
        bcdAdj[4*i +: 4] = bcdReg[4*i +: 4] + 4'd3;
      end
    end
  end

  // Significant digit count: position of the highest nonzero digit, at least one
  always_comb begin
    sigCount = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcdReg[4*i +: 4] != 4'd0) begin
        sigCount = 4'(i + 1);
      end
    end
  end

  // Track start every cycle; resets high so a start held through reset is not an edge
  always_ff @(posedge clock) begin
    if (reset) begin
      startPrev <= 1'b1;
    end else begin
      startPrev <= fmt.start;
    end
  end

  // Sequencer: idle -> 34 shift cycles -> strip loop -> output capture -> done pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      iterCnt  <= 6'd0;
      stripCnt <= 4'd0;
      fmt.busy <= 1'b0;
      fmt.done <= 1'b0;
    end else begin
      fmt.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (startRise) begin
            state    <= S_CONVERT;
            iterCnt  <= 6'd0;
            stripCnt <= 4'd0;
            fmt.busy <= 1'b1;
          end
        end
        S_CONVERT: begin
          iterCnt <= iterCnt + 6'd1;
          if (iterCnt == LAST_ITER) begin
            state <= S_STRIP;
          end
        end
        S_STRIP: begin
          if (canStrip) begin
            stripCnt <= stripCnt + 4'd1;
          end else begin
            state <= S_COUNT;
          end
        end
        S_COUNT: begin
          state <= S_DONE;
        end
        S_DONE: begin
          fmt.done <= 1'b1;
          fmt.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Working registers: operand capture, BCD accumulation and exponent adjustment
  always_ff @(posedge clock) begin
    if (reset) begin
      signReg <= 1'b0;
      expReg  <= 7'sd0;
      mantReg <= '0;
      bcdReg  <= '0;
      satFlag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (startRise) begin
            signReg <= fmt.signIn;
            expReg  <= fmt.expIn;
            mantReg <= fmt.mantIn;
            bcdReg  <= '0;
            satFlag <= 1'b0;
          end
        end
        S_CONVERT: begin
          bcdReg  <= {bcdAdj[BCD_W-2:0], mantReg[MANT_W-1]};
          mantReg <= {mantReg[MANT_W-2:0], 1'b0};
        end
        S_STRIP: begin
          if (canStrip) begin
            bcdReg <= {4'd0, bcdReg[BCD_W-1:4]};
            expReg <= expReg + 7'sd1;
          end else if (digit0Zero && upperNonZero && expAtMax) begin
            satFlag <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers: updated only in the capture state, otherwise held; zero is always +0 x 10^0
  always_ff @(posedge clock) begin
    if (reset) begin
      fmt.signOut   <= 1'b0;
      fmt.digits    <= '0;
      fmt.numDigits <= 4'd1;
      fmt.expOut    <= 7'd0;
      fmt.expSat    <= 1'b0;
    end else if (state == S_COUNT) begin
      if (bcdZero) begin
        fmt.signOut   <= 1'b0;
        fmt.digits    <= '0;
        fmt.numDigits <= 4'd1;
        fmt.expOut    <= 7'd0;
        fmt.expSat    <= 1'b0;
      end else begin
        fmt.signOut   <= signReg;
        fmt.digits    <= bcdReg;
        fmt.numDigits <= sigCount;
        fmt.expOut    <= expReg;
        fmt.expSat    <= satFlag;
      end
    end
  end
endmodule

// File: tb/tb_result_formatter.sv
// tb/tb_result_formatter.sv - self-checking bench for result_formatter
module tb_result_formatter;
  typedef struct packed {
    logic        sign;
    logic [43:0] dig;
    logic [3:0]  num;
    logic [6:0]  exp;
    logic        sat;
    logic [31:0] z;
  } fmtRes_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  result_formatter_if fmt ();

  result_formatter dut (
    .clock (clock),
    .reset (reset),
    .fmt   (fmt)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result from plain decimal arithmetic
  function automatic fmtRes_t modelFmt(input logic s, input logic [33:0] m, input logic signed [6:0] e);
    fmtRes_t r;
    longint  v;
    longint  t;
    int      ex;
    int      n;
    r.sign = s;
    r.dig  = '0;
    r.num  = 4'd1;
    r.exp  = 7'd0;
    r.sat  = 1'b0;
    r.z    = 32'd0;
    v  = longint'(m);
    ex = int'(e);
    if (v == 0) begin
      r.sign = 1'b0;
      return r;
    end
    while ((v % 10 == 0) && (ex < 63)) begin
      v   = v / 10;
      ex  = ex + 1;
      r.z = r.z + 32'd1;
    end
    r.sat = (v % 10 == 0);
    r.exp = 7'(ex);
    n = 0;
    t = v;
    while (t > 0) begin
      n = n + 1;
      t = t / 10;
    end
    r.num = 4'(n);
    for (int i = 0; i < 11; i++) begin
      r.dig[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Timing model: accept on a start rise while idle, outputs change 36+z edges later, done at 37+z
  fmtRes_t     cur;
  fmtRes_t     pend = '0;
  logic        mPrev = 1'b1;
  logic        mBusy = 1'b0;
  logic        mDone = 1'b0;
  logic        mSign = 1'b0;
  logic [43:0] mDig = '0;
  logic [3:0]  mNum = 4'd1;
  logic [6:0]  mExp = 7'd0;
  logic        mSat = 1'b0;
  int          mCnt = 0;

  always_comb cur = modelFmt(fmt.signIn, fmt.mantIn, fmt.expIn);

  always @(posedge clock) begin
    if (reset) begin
      mPrev <= 1'b1;
      mBusy <= 1'b0;
      mDone <= 1'b0;
      mSign <= 1'b0;
      mDig  <= '0;
      mNum  <= 4'd1;
      mExp  <= 7'd0;
      mSat  <= 1'b0;
      mCnt  <= 0;
    end else begin
      mPrev <= fmt.start;
      mDone <= 1'b0;
      if (!mBusy) begin
        if (fmt.start && !mPrev) begin
          pend  <= cur;
          mBusy <= 1'b1;
          mCnt  <= 37 + int'(cur.z);
        end
      end else begin
        mCnt <= mCnt - 1;
        if (mCnt == 2) begin
          mSign <= pend.sign;
          mDig  <= pend.dig;
          mNum  <= pend.num;
          mExp  <= pend.exp;
          mSat  <= pend.sat;
        end
        if (mCnt == 1) begin
          mDone <= 1'b1;
          mBusy <= 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clock) begin
    if (cyc > 0) begin
      check("busy", fmt.busy, mBusy);
      check("done", fmt.done, mDone);
      check("signOut", fmt.signOut, mSign);
      check("digits", fmt.digits, mDig);
      check("numDigits", fmt.numDigits, mNum);
      check("expOut", fmt.expOut, mExp);
      check("expSat", fmt.expSat, mSat);
    end
  end

  task automatic doConv(input logic s, input logic [33:0] m, input logic [6:0] e, input int lat,
                        input logic [43:0] dig, input logic [3:0] num, input logic [6:0] ex,
                        input logic sgn, input logic sat);
    int c0;
    fmt.signIn = s;
    fmt.mantIn = m;
    fmt.expIn  = e;
    fmt.start  = 1'b1;
    @(negedge clock);
    c0 = cyc;
    fmt.start  = 1'b0;
    fmt.signIn = ~s;
    fmt.mantIn = ~m;
    fmt.expIn  = ~e;
    for (int i = 0; i < 80; i++) begin
      if (fmt.done) break;
      @(negedge clock);
    end
    check("lit_latency", fmt.done ? longint'(cyc - c0) : -1, lat);
    check("lit_digits", fmt.digits, dig);
    check("lit_numDigits", fmt.numDigits, num);
    check("lit_expOut", fmt.expOut, ex);
    check("lit_signOut", fmt.signOut, sgn);
    check("lit_expSat", fmt.expSat, sat);
  endtask

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    fmtRes_t t;
    logic    doneSeen;

    fmt.start  = 1'b0;
    fmt.signIn = 1'b0;
    fmt.mantIn = '0;
    fmt.expIn  = '0;

    t = modelFmt(1'b1, 34'd12345000, -7'sd3);
    check("model_dig_a", t.dig, 44'h12345);
    check("model_z_a", t.z, 3);
    check("model_num_a", t.num, 5);
    t = modelFmt(1'b0, 34'd1000, 7'sd61);
    check("model_dig_b", t.dig, 44'h10);
    check("model_exp_b", t.exp, 63);
    check("model_sat_b", t.sat, 1);

    repeat (3) @(negedge clock);
    check("rst_busy", fmt.busy, 0);
    check("rst_done", fmt.done, 0);
    check("rst_digits", fmt.digits, 0);
    check("rst_numDigits", fmt.numDigits, 1);
    check("rst_expOut", fmt.expOut, 0);
    reset = 1'b0;
    @(negedge clock);

    doConv(1'b1, 34'd12345000,     7'h7D, 40, 44'h12345,       4'd5,  7'h00, 1'b1, 1'b0);
    doConv(1'b0, 34'd17179869183,  7'h00, 37, 44'h17179869183, 4'd11, 7'h00, 1'b0, 1'b0);
    doConv(1'b1, 34'd0,            7'h05, 37, 44'h0,           4'd1,  7'h00, 1'b0, 1'b0);
    doConv(1'b0, 34'd1000,         7'h3D, 39, 44'h10,          4'd2,  7'h3F, 1'b0, 1'b1);
    doConv(1'b0, 34'd10,           7'h3F, 37, 44'h10,          4'd2,  7'h3F, 1'b0, 1'b1);
    doConv(1'b1, 34'd500,          7'h40, 39, 44'h5,           4'd1,  7'h42, 1'b1, 1'b0);
    doConv(1'b0, 34'd10000000000,  7'h00, 47, 44'h1,           4'd1,  7'h0A, 1'b0, 1'b0);

    // Abort: start, second start while busy, reset mid-conversion
    fmt.signIn = 1'b1;
    fmt.mantIn = 34'd987654;
    fmt.expIn  = 7'h02;
    fmt.start  = 1'b1;
    @(negedge clock);
    fmt.start = 1'b0;
    repeat (9) @(negedge clock);
    fmt.start = 1'b1;
    @(negedge clock);
    fmt.start = 1'b0;
    check("abort_busy_mid", fmt.busy, 1);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_busy_drop", fmt.busy, 0);
    reset = 1'b0;
    doneSeen = 1'b0;
    repeat (50) begin
      @(negedge clock);
      if (fmt.done) doneSeen = 1'b1;
    end
    check("abort_no_done", doneSeen, 0);
    check("abort_digits", fmt.digits, 0);
    check("abort_numDigits", fmt.numDigits, 1);
    check("abort_signOut", fmt.signOut, 0);

    // Start held high across reset release must not trigger
    fmt.mantIn = 34'd7;
    fmt.start  = 1'b1;
    reset      = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("held_no_busy", fmt.busy, 0);
    fmt.start = 1'b0;
    @(negedge clock);
    doConv(1'b0, 34'd7, 7'h00, 37, 44'h7, 4'd1, 7'h00, 1'b0, 1'b0);
    @(negedge clock);
    check("held_single_done", fmt.done, 0);
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/result_formatter.md
# result_formatter

Post-arithmetic formatter downstream of the divider (and the other arithmetic units that share its result format). It takes a sign/mantissa/exponent result and converts the 34-bit binary mantissa to 11 packed BCD digits using iterative double-dabble, one bit per cycle. It then strips trailing decimal zeros into the exponent and reports the significant-digit count for the display driver.

## Interface
Parameters:
- MANT_W, 34, mantissa width in bits (fixed; the max input is 17179869183).
- DIGITS, 11, number of BCD output digits.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level input; a 0→1 transition sampled on a clock edge requests a conversion.
- signIn  in  1  result sign.
- mantIn  in  34  unsigned result mantissa.
- expIn  in  7  signed base-10 exponent.
- busy  out  1  high from the edge that accepts start until the edge that raises done.
- done  out  1  single-cycle completion pulse.
- signOut  out  1  formatted sign.
- digits  out  44  11 BCD digits; [3:0] is the least significant digit.
- numDigits  out  4  significant digit count, 1..11.
- expOut  out  7  signed adjusted exponent.
- expSat  out  1  set when stripping stopped because expOut reached +63.

## Operation
- Edge detect: startPrev is registered every cycle. It resets to 1, so a start held high through reset does not trigger a conversion.
- Result value represented: (−1)^signOut × digits × 10^expOut.
- S_IDLE: on a start rising edge, latch signIn, mantIn and expIn, clear the BCD accumulator, set busy, and go to S_CONVERT. Otherwise stay in S_IDLE.
- S_CONVERT: 34 iterations, one per cycle, driven by a 6-bit counter.
  - Each iteration: first add 3 to every BCD nibble ≥ 5.
  - Then shift {bcd, mant} left by one.
  - After iteration 34, go to S_STRIP.
- S_STRIP: one digit per cycle.
  - If digit0 == 0, the upper digits are nonzero, and exp < 63: shift the digits right by 4 and increment exp.
  - Else: set the saturation flag if the loop ended due to exp == 63 while digit0 == 0 with nonzero upper digits, then go to S_COUNT.
  - At most 10 strips.
- S_COUNT: register all outputs.
  - numDigits = index of the highest nonzero digit + 1.
  - Zero mantissa: digits = 0, numDigits = 1, expOut = 0, signOut = 0 (−0 is normalised to +0).
  - Go to S_DONE.
- S_DONE: done <= 1, busy <= 0, go to S_IDLE. done is cleared on every other cycle.
- Arithmetic: exp is kept as 7-bit signed and never wraps. Only increments occur, and they are clamped at +63.
- A start edge while busy is ignored and not queued; startPrev still tracks the input.
- Outputs hold their values until the next S_COUNT overwrites them.

## Timing
- Reset (synchronous), all outputs: busy = 0, done = 0, signOut = 0, digits = 0, numDigits = 1, expOut = 0, expSat = 0. State goes to S_IDLE.
- Reset mid-conversion aborts the conversion; no done pulse follows.
- Let E0 be the edge that samples the start rise, and z the number of digits stripped.
  - Conversion runs on E1..E34.
  - Strips run on E35..E34+z; the terminating STRIP cycle is E35+z.
  - S_COUNT runs on E36+z, which updates the outputs.
  - done is high for exactly one cycle after E37+z.
  - busy is high after E0 through E37+z.
- Latency ranges from 37 cycles (z = 0) to 47 cycles (z = 10).
- Back-to-back: a start rise sampled on the edge after done is accepted normally.
- Inputs are sampled only at E0; they may change freely afterwards.

## Test plan
- signIn = 1, mantIn = 12345000, expIn = −3:
  - digits = 0x12345, numDigits = 5, expOut = 0, signOut = 1, expSat = 0.
  - done one cycle after E40.
- mantIn = 17179869183, expIn = 0:
  - digits = 0x17179869183, numDigits = 11, expOut = 0.
  - done after E37 (no strips).
- signIn = 1, mantIn = 0, expIn = 5:
  - digits = 0, numDigits = 1, expOut = 0, signOut = 0.
  - done after E37.
- mantIn = 1000, expIn = 61:
  - Two strips, then stop at 63: digits = 0x10, numDigits = 2, expOut = 63, expSat = 1.
- Start at E0, pulse start again at E10, then reset at E20:
  - busy drops after E20.
  - No done pulse within the following 50 cycles.
  - Outputs stay at reset values.
- Hold start high through reset release:
  - No conversion occurs.
  - Then drop start and raise it again: a conversion runs and done pulses once.
